// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and types for the VGA timing controller.
//   DEF_*          default 640x480@60 timing (pixels / lines)
//   h_total()      horizontal period from the four phase lengths
//   v_total()      vertical period from the four phase lengths
//   phase_t        phase of a line or frame: active, front porch, sync, back porch
//   next_phase()   phase that follows a given phase
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        unique case (ph)
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYNC;
            PH_SYNC: nxt = PH_BP;
            PH_BP:   nxt = PH_ACT;
            default: nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_phase_fsm.sv
// vga_phase_fsm: four-phase (active, front porch, sync, back porch) sequencer with a
// position counter; used once per axis.
//   clk, reset    system clock, asynchronous active-high reset
//   step          advance by one position (pixel or line)
//   phase         current phase
//   phase_next    phase after this cycle (for registered decodes in the parent)
//   count         position within the period, 0..ACT+FP+SYNC+BP-1
//   wrap          step on the last position of the period (count returns to 0)
module vga_phase_fsm
    import vga_pkg::*;
#(
    parameter int unsigned ACT  = DEF_H_ACTIVE,
    parameter int unsigned FP   = DEF_H_FP,
    parameter int unsigned SYNC = DEF_H_SYNC,
    parameter int unsigned BP   = DEF_H_BP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output phase_t     phase,
    output phase_t     phase_next,
    output logic [9:0] count,
    output logic       wrap
);

    phase_t     phase_q, phase_d;
    logic [9:0] pcnt_q, pcnt_d;    // position within the current phase
    logic [9:0] count_q, count_d;
    logic [9:0] last_idx;
    logic       last;

    always_comb begin
        last_idx = '0;
        unique case (phase_q)
            PH_ACT:  last_idx = 10'(ACT - 1);
            PH_FP:   last_idx = 10'(FP - 1);
            PH_SYNC: last_idx = 10'(SYNC - 1);
            PH_BP:   last_idx = 10'(BP - 1);
            default: last_idx = '0;
        endcase
    end

    assign last = (pcnt_q == last_idx);
    assign wrap = step && last && (phase_q == PH_BP);

    always_comb begin
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + 10'd1;
            if (last) begin
                pcnt_d  = '0;
                phase_d = next_phase(phase_q);
            end else begin
                pcnt_d = pcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_ACT;
            pcnt_q  <= '0;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
        end
    end

    assign phase      = phase_q;
    assign phase_next = phase_d;
    assign count      = count_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-tick divider plus horizontal/vertical timing generator.
//   clk, reset    system clock, asynchronous active-high reset
//   en            run enable; low freezes every counter and output register
//   pix_en        one-clk pixel tick every CLK_DIV enabled clocks
//   x, y          current pixel / line position
//   hsync_n       horizontal sync, active low
//   vsync_n       vertical sync, active low
//   blank_n       high only inside the visible area
//   line_start    pulse with the tick that returns x to 0
//   frame_start   pulse with the tick that returns (x,y) to (0,0)
// Build option: define VGA_SYNC_DELAY_EN to delay hsync_n/vsync_n/blank_n by one pixel
// tick, matching a pixel path with one pixel of latency.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("H_TOTAL must not exceed 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_clk_div_chk
        $error("CLK_DIV must be at least 1");
    end

    // Pixel-tick divider
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        end
    end

    assign pix_en = en && !reset && (div_q == DIV_W'(CLK_DIV - 1));

    // Axis sequencers
    phase_t h_phase, h_phase_next, v_phase, v_phase_next;
    logic   h_wrap, v_wrap, v_step;

    assign v_step = pix_en && h_wrap;

    vga_phase_fsm #(
        .ACT  (H_ACTIVE),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_fsm (
        .clk        (clk),
        .reset      (reset),
        .step       (pix_en),
        .phase      (h_phase),
        .phase_next (h_phase_next),
        .count      (x),
        .wrap       (h_wrap)
    );

    vga_phase_fsm #(
        .ACT  (V_ACTIVE),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_fsm (
        .clk        (clk),
        .reset      (reset),
        .step       (v_step),
        .phase      (v_phase),
        .phase_next (v_phase_next),
        .count      (y),
        .wrap       (v_wrap)
    );

    assign line_start  = h_wrap;
    assign frame_start = v_wrap;

    // Decodes are taken from the next-state phases so they land on the same edge as x,y.
    logic hs_q, vs_q, bl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b1;
        end else if (pix_en) begin
            hs_q <= (h_phase_next != PH_SYNC);
            vs_q <= (v_phase_next != PH_SYNC);
            bl_q <= (h_phase_next == PH_ACT) && (v_phase_next == PH_ACT);
        end
    end

    a_hsync_phase: assert property (@(posedge clk) disable iff (reset)
        (h_phase == PH_SYNC) == !hs_q);
    a_vsync_phase: assert property (@(posedge clk) disable iff (reset)
        (v_phase == PH_SYNC) == !vs_q);

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_q, vs_dly_q, bl_dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
            bl_dly_q <= 1'b1;
        end else if (pix_en) begin
            hs_dly_q <= hs_q;
            vs_dly_q <= vs_q;
            bl_dly_q <= bl_q;
        end
    end

    assign hsync_n = hs_dly_q;
    assign vsync_n = vs_dly_q;
    assign blank_n = bl_dly_q;
`else
    assign hsync_n = hs_q;
    assign vsync_n = vs_q;
    assign blank_n = bl_q;
`endif

endmodule
